// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared region encoding and bus sizing for the memory/I-O responder
package mem_io_pkg;
  localparam int DW = 9;
  localparam int RAM_AW = 7;
  typedef enum logic [1:0] {
    RAM = 2'b00,
    LED = 2'b01,
    SW  = 2'b10,
    CNT = 2'b11
  } region_t;
endpackage

// File: rtl/sync_ram_128x9.sv
// sync_ram_128x9: single write port, registered read-first read port, no array reset
// clk; we_i/waddr_i/wdata_i write port; raddr_i -> rdata_o one edge later (old word on collision)
module sync_ram_128x9 #(
  parameter int DW = 9,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: decodes RAM/LED/switch/counter regions behind the processor bus, 1-cycle read latency
// clk, rst (async high); addr_i/dout_i/w_d_i processor bus -> din_o; sw_i -> synchronized switches;
// led_o LED register; load_valid_i/load_addr_i/load_data_i -> load_ready_o loader port into RAM
module mem_io_responder #(
  parameter int DW = mem_io_pkg::DW,
  parameter int RAM_AW = mem_io_pkg::RAM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RAM_AW+1:0] addr_i,
  input  logic [DW-1:0]     dout_i,
  input  logic              w_d_i,
  output logic [DW-1:0]     din_o,
  input  logic [DW-1:0]     sw_i,
  output logic [DW-1:0]     led_o,
  input  logic              load_valid_i,
  input  logic [RAM_AW-1:0] load_addr_i,
  input  logic [DW-1:0]     load_data_i,
  output logic              load_ready_o
);
  import mem_io_pkg::*;
  region_t region;
  logic [DW-1:0] led_q, led_d, cnt_q, cnt_d, sw1_q, sw2_q, oth_q, oth_d, ram_rd;
  logic ram_sel_q, ram_we;
  assign region = region_t'(addr_i[RAM_AW+1:RAM_AW]);
  assign load_ready_o = load_valid_i & ~w_d_i & ~rst;
  // RAM array has no reset, so a write coinciding with reset is suppressed here
  assign ram_we = (w_d_i & (region == RAM) & ~rst) | load_ready_o;
  always_comb begin
    led_d = (w_d_i && region == LED) ? dout_i : led_q;
    cnt_d = (w_d_i && region == CNT) ? dout_i : cnt_q + DW'(1);
    oth_d = (region == LED) ? led_q : (region == SW) ? sw2_q : cnt_q;
  end
  // din_o is a mux of registers; ram_sel_q resets to 0 so din_o clears with oth_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q     <= '0;
      cnt_q     <= '0;
      sw1_q     <= '0;
      sw2_q     <= '0;
      oth_q     <= '0;
      ram_sel_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      cnt_q     <= cnt_d;
      sw1_q     <= sw_i;
      sw2_q     <= sw1_q;
      oth_q     <= oth_d;
      ram_sel_q <= (region == RAM);
    end
  end
  sync_ram_128x9 #(.DW(DW), .AW(RAM_AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (w_d_i ? addr_i[RAM_AW-1:0] : load_addr_i),
    .wdata_i (w_d_i ? dout_i : load_data_i),
    .raddr_i (addr_i[RAM_AW-1:0]),
    .rdata_o (ram_rd)
  );
  assign din_o = ram_sel_q ? ram_rd : oth_q;
  assign led_o = led_q;
endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory and I/O responder at the far end of the processor's address/data bus. It receives the processor's registered address, write data and write strobe, and returns read data with one cycle of latency. It decodes four regions: a 128-word RAM, an LED register, synchronized switch inputs and a loadable cycle counter. A program-loader port fills RAM while the processor idles or runs.

## Interface
Parameters:
- DW, 9: bus data width.
- RAM_AW, 7: RAM address width (128 words).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- addr_i  in  9  processor ADDR register output.
- dout_i  in  9  processor DOUT register output (write data).
- w_d_i  in  1  processor write strobe; one-cycle pulse.
- din_o  out  9  read data to processor Din.
- sw_i  in  9  asynchronous switch inputs.
- led_o  out  9  LED register.
- load_valid_i  in  1  loader request.
- load_addr_i  in  7  loader RAM address.
- load_data_i  in  9  loader RAM data.
- load_ready_o  out  1  loader accepted this cycle.

## Operation
- Region decode on addr_i[8:7]:
  - 00: RAM[addr_i[6:0]].
  - 01: LED register.
  - 10: switches, read-only.
  - 11: cycle counter.
- Processor write: when w_d_i=1, dout_i is written to the decoded region at the clock edge.
  - A write to region 10 is ignored.
  - A write to region 11 loads the counter with dout_i. The load wins over the increment in that cycle.
- Read: at every edge, din_o is registered from the region selected by addr_i.
  - Reads are continuous; there is no read strobe.
- RAM read-during-write (same address, same edge): din_o returns the old word. The new word is visible one cycle later.
- Switches: two-flop synchronizer per bit. Reads return the second stage.
- Counter: 9-bit, increments every cycle and wraps 511→0.
- Loader arbitration: load_ready_o = load_valid_i & ~w_d_i & ~rst.
  - The RAM is written with load_data_i at load_addr_i when load_ready_o=1.
  - A processor write to any region blocks the loader for that cycle. The loader holds its request until accepted.
  - A processor write to region 01, 10 or 11 also blocks the loader. Arbitration stays single-rule.
- Loader writes follow the same read-during-write rule as processor writes.

## Timing
- Reset values while rst=1, asynchronously: din_o=0, led_o=0, counter=0, synchronizer flops=0, load_ready_o=0.
- RAM contents are not reset.
- Read latency is 1 cycle: an address stable at edge N gives din_o valid after edge N. This matches the processor's one-cycle gap between loading ADDR and capturing Din.
- Write latency: the written value is readable from the next edge. A read of that address after edge N+1 returns it.
- Switch latency: a change on sw_i appears on din_o 3 edges later when region 10 is addressed.
- Reset asserted mid-write: the write is discarded if rst is high at the edge.
  - The loader handshake is dropped. The loader must re-present its request after reset release.
- Reset release: the counter reads 0 at the first edge after deassertion, then increments.

## Structure
- Package mem_io_pkg:
  - region_t enum: RAM=2'b00, LED=2'b01, SW=2'b10, CNT=2'b11.
  - DW and RAM_AW constants.
- Sub-module sync_ram_128x9:
  - One write port, one synchronous read port.
  - Read-first behaviour.
  - No reset on the array.
- Top level contains the decode, the LED register, synchronizer, counter, arbiter and read mux/register.

## Test plan
- RAM write/read: write dout_i=9'h1A5 with addr=9'h005 and w_d_i=1, then hold addr=9'h005. Required: din_o=9'h1A5 one edge later.
- Read-during-write: RAM[3]=9'h011, then write 9'h022 to addr 3 while addressed. Required: din_o=9'h011 after the write edge and 9'h022 after the following edge.
- LED and switches:
  - Write 9'h0F0 to addr 9'h080. Required: led_o=9'h0F0.
  - Set sw_i=9'h155 and address 9'h100. Required: din_o=9'h155 after 3 edges.
  - Write 9'h0AA to addr 9'h100. Required: no state change.
- Counter:
  - Write 9'h1FE to addr 9'h180. Required: reads return 9'h1FE, 9'h1FF, 9'h000 on successive edges.
  - Release reset. Required: counter=0.
- Loader contention:
  - load_valid_i=1 (addr 7'h10, data 9'h077) together with w_d_i=1. Required: load_ready_o=0.
  - Next cycle with w_d_i=0. Required: load_ready_o=1, and RAM[16]=9'h077 on readback.
- Async reset mid-operation: assert rst between edges while led_o=9'h0F0 and din_o≠0. Required: led_o=0, din_o=0 and load_ready_o=0 immediately, before the next edge.
